// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin owner of the shared MIPS memory port; sequences each
//            access (start, wait for done, report done or timeout error).
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic mem_done,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic mem_start,
  output logic done0,
  output logic done1,
  output logic err0,
  output logic err1,
  output logic busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state_q;
  logic             last_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             sel_q;
  logic             start_q;
  logic             busy_q;
  logic             err0_q;
  logic             err1_q;
  logic [CNT_W-1:0] cnt_q;

  logic             win_d;
  logic             tmo_hit_d;

  // On contention the requester that did not win last time goes next.
  always_comb begin
    win_d = req1;
    if (req0 && req1) begin
      win_d = ~last_q;
    end
  end

  always_comb begin
    tmo_hit_d = 1'b0;
    if (TIMEOUT > 0) begin
      tmo_hit_d = (cnt_q == C_CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      sel_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      start_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            state_q <= S_BUSY;
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
            sel_q   <= win_d;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            last_q  <= win_d;
            cnt_q   <= '0;
          end
        end
        S_BUSY: begin
          if (mem_done) begin
            state_q <= S_IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (tmo_hit_d) begin
            // Completion takes priority; abort only when no done arrived.
            state_q <= S_IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            err0_q  <= gnt0_q;
            err1_q  <= gnt1_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign sel       = sel_q;
  assign mem_start = start_q;
  assign busy      = busy_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign done0     = gnt0_q & mem_done;
  assign done1     = gnt1_q & mem_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench: directed vector table, corner sequences and
//            random traffic against a transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

  localparam int C_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset, req0, req1, mem_done;
  logic gnt0, gnt1, sel, mem_start, done0, done1, err0, err1, busy;

  mem_port_arbiter #(.TIMEOUT(C_TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .mem_done(mem_done),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .mem_start(mem_start),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one in-flight transaction described by owner and age.
  logic       m_inflight = 1'b0;
  logic       m_owner    = 1'b0;
  logic       m_last     = 1'b1;
  logic       m_sel      = 1'b0;
  int         m_age      = 0;
  logic [1:0] m_err      = 2'b00;
  logic       warm       = 1'b0;
  logic [8:0] obs;

  typedef struct {
    logic       rst;
    logic       r0;
    logic       r1;
    logic       md;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [8:0] model_out(input logic md);
    logic o0, o1;
    o0 = m_inflight && (m_owner == 1'b0);
    o1 = m_inflight && (m_owner == 1'b1);
    return {o0, o1, m_sel, m_inflight && (m_age == 0), o0 && md, o1 && md,
            m_err[0], m_err[1], m_inflight};
  endfunction

  task automatic model_edge(input logic rs, input logic a, input logic b, input logic md);
    if (rs) begin
      m_inflight = 1'b0;
      m_last     = 1'b1;
      m_sel      = 1'b0;
      m_age      = 0;
      m_err      = 2'b00;
    end else begin
      m_err = 2'b00;
      if (m_inflight) begin
        if (md) begin
          m_inflight = 1'b0;
        end else if (C_TIMEOUT > 0 && m_age + 1 == C_TIMEOUT) begin
          m_inflight       = 1'b0;
          m_err[m_owner]   = 1'b1;
        end else begin
          m_age = m_age + 1;
        end
      end else if (a || b) begin
        m_owner    = (a && b) ? ~m_last : b;
        m_last     = m_owner;
        m_sel      = m_owner;
        m_inflight = 1'b1;
        m_age      = 0;
      end
    end
  endtask

  task automatic step(input logic rs, input logic a, input logic b, input logic md,
                      input logic use_tbl, input logic [8:0] texp);
    @(negedge clk);
    reset = rs; req0 = a; req1 = b; mem_done = md;
    #1;
    obs = {gnt0, gnt1, sel, mem_start, done0, done1, err0, err1, busy};
    if (warm) begin
      chk("model", {23'd0, obs}, {23'd0, model_out(md)});
      if (use_tbl) chk("table", {23'd0, obs}, {23'd0, texp});
      if (gnt0 && gnt1) chk("gnt_exclusive", 32'd1, 32'd0);
    end
    model_edge(rs, a, b, md);
  endtask

  int n_busy, n_err1, n_done1;

  initial begin
    // Outputs: {gnt0,gnt1,sel,mem_start,done0,done1,err0,err1,busy}
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b000000000};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9'b000000000};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9'b100100001};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9'b100000001};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 9'b100010001};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b000000000};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000000000};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 9'b011101001};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b001000000};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 9'b001000000};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 9'b001000000};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 9'b100100001};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 9'b100010001};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000000000};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b011100001};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b011000001};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 9'b011001001};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b001000000};

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; mem_done = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
    warm = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].md, 1'b1, tbl[i].exp);
    end

    // Timeout on requester 1 while requester 0 waits.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0);
    n_busy = 0; n_err1 = 0; n_done1 = 0;
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, (i < 16) ? 1'b1 : 1'b0, 1'b0, 1'b0, 9'd0);
      n_busy  += int'(obs[0]);
      n_err1  += int'(obs[1]);
      n_done1 += int'(obs[3]);
    end
    chk("timeout_busy_cycles", n_busy, 16);
    chk("timeout_err1_pulses", n_err1, 1);
    chk("timeout_no_done1", n_done1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
    chk("after_timeout_gnt0", {31'd0, obs[8]}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);

    // mem_done arriving exactly on the timeout cycle.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'd0);
    chk("coincident_done0", {31'd0, obs[4]}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
    chk("coincident_no_err0", {31'd0, obs[2]}, 32'd0);
    chk("coincident_idle", {31'd0, obs[0]}, 32'd0);

    // Reset in the third BUSY cycle, then contention restarts at requester 0.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0);
    chk("post_reset_outputs", {23'd0, obs}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0);
    chk("post_reset_gnt0_first", {30'd0, obs[8:7]}, 32'd2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(9) < 6), ($urandom_range(9) < 6),
           ($urandom_range(9) < 3), 1'b0, 9'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester controller for the single shared memory port of the MIPS core.
- Requester 0 is instruction fetch; requester 1 is the data-memory stage.
- Arbitrates between them round-robin and drives the select of the 2:1 address/data muxes in front of the port (sel=0 routes requester 0, sel=1 routes requester 1).
- Sequences each access: start pulse, wait for memory completion, completion/error reporting back to the winning requester.

Parameters:
- TIMEOUT, default 16: max BUSY cycles waiting for mem_done before abort; 0 disables the timeout.
- CNT_W, default 8: width of the wait counter; TIMEOUT must be < 2^CNT_W.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  access request from instruction fetch
- req1  input  1  access request from data stage
- mem_done  input  1  memory port reports access complete (valid only in BUSY)
- gnt0  output  1  requester 0 owns the port
- gnt1  output  1  requester 1 owns the port
- sel  output  1  mux select to datapath (0 = requester 0, 1 = requester 1)
- mem_start  output  1  one-cycle pulse launching the memory access
- done0  output  1  completion strobe to requester 0
- done1  output  1  completion strobe to requester 1
- err0  output  1  timeout-abort strobe to requester 0
- err1  output  1  timeout-abort strobe to requester 1
- busy  output  1  a transaction is in progress

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset (any cycle, including mid-transaction):
  - state=IDLE, last_grant=1, wait counter=0.
  - gnt0=gnt1=0, sel=0, mem_start=0, done0=done1=0, err0=err1=0, busy=0.
  - Any in-flight access is dropped without a done or err strobe.
- States: IDLE, BUSY.
- IDLE:
  - gnt0=gnt1=0, busy=0; sel holds its last value.
  - If only one req is high, that requester wins.
  - If both are high, the requester not equal to last_grant wins (round-robin). After reset, requester 0 wins first.
  - Winner registered at the edge. Next cycle: state=BUSY, gnt_w=1, sel=w, busy=1, mem_start=1, last_grant=w, counter=0.
  - No req: stay IDLE.
  - mem_done in IDLE is ignored.
- BUSY:
  - gnt_w, sel and busy are held constant; mem_start is high only in the first BUSY cycle.
  - Counter increments every BUSY cycle in which mem_done=0.
  - done_w = gnt_w AND mem_done, combinational, same cycle as mem_done. At that edge: state=IDLE, gnt cleared.
  - mem_done is accepted in the first BUSY cycle (concurrent with mem_start), giving a 2-cycle minimum transaction.
  - Timeout (TIMEOUT>0): mem_done=0 with counter==TIMEOUT-1 → state=IDLE. err_w is a registered pulse, high exactly one cycle (the first IDLE cycle).
  - mem_done and the timeout condition in the same cycle: done wins, no err.
  - A req drop during BUSY does not abort; the transaction runs to done or timeout.
  - The non-granted req is ignored until IDLE.
- Handshake contract:
  - Requester holds req high until it samples done or err, then deasserts req at that edge.
  - At least one IDLE cycle separates transactions, so request-to-start latency is 1 cycle from IDLE.
  - A requester that keeps req high after done is treated as a new request.
- Invariants:
  - gnt0 AND gnt1 is never 1.
  - sel==1 whenever gnt1=1, and sel==0 whenever gnt0=1.
  - done_x and err_x never high in the same cycle.
  - mem_start is never high outside the first BUSY cycle.

Test Plan:
- Reset, then req0=1 only at cycle 2 → cycle 3: gnt0=1, sel=0, mem_start=1, busy=1. mem_done at cycle 5 → done0=1 at cycle 5. Cycle 6: IDLE, gnt0=0.
- req0=req1=1 continuously, mem_done 2 cycles after each start → grants alternate 0,1,0,1, with one IDLE cycle between each; sel follows the grant; never both gnt high.
- req1 granted, mem_done held 0, TIMEOUT=16 → BUSY for 16 cycles, then IDLE; err1=1 for exactly one cycle; done1 never asserted; next grant goes to req0 if pending.
- mem_done asserted in the same cycle as mem_start → done strobe that cycle; state IDLE next cycle; 2-cycle transaction.
- reset asserted in the 3rd BUSY cycle of a req0 access → next cycle all outputs 0, state IDLE. With req0=req1=1 afterward, requester 0 is granted first (last_grant=1).
- Requester drops req mid-BUSY; mem_done pulsed while IDLE; mem_done coincident with the timeout cycle → grant held to completion; IDLE mem_done has no effect; coincident case gives done=1, err=0.
